// File: rtl/triumph_wb_arbiter.sv
// Register-file write-port arbiter: shares one write port between the ALU (EX)
// and the load unit (LSU). LSU wins conflicts unless EX has been starved too long.
module triumph_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_addr_i,
  input  logic [31:0] ex_data_i,
  output logic        ex_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        rf_src_o,
  output logic [2:0]  starve_cnt_o
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  // Saturating increment keeps the loss count from ever passing LIMIT.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= LIMIT) ? LIMIT : v + 3'd1;
  endfunction

  logic [2:0]  starve_q, starve_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        src_q, src_d;
  logic        ex_grant, lsu_grant;
  logic        starved;

  assign starved = (starve_q == LIMIT);

  // Grant decision looks only at the valids and the loss count, never at payload.
  always_comb begin
    ex_grant  = 1'b0;
    lsu_grant = 1'b0;
    if (!rst_i) begin
      ex_grant  = ex_valid_i && (!lsu_valid_i || starved);
      lsu_grant = lsu_valid_i && !ex_grant;
    end
  end

  assign ex_ready_o  = ex_grant;
  assign lsu_ready_o = lsu_grant;

  always_comb begin
    starve_d = 3'd0;
    if (ex_valid_i && lsu_valid_i && !ex_grant) begin
      starve_d = sat_inc(starve_q);
    end
  end

  // Writes to x0 are accepted but suppressed at the enable; payload still updates.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    if (ex_grant) begin
      we_d    = (ex_addr_i != 5'd0);
      waddr_d = ex_addr_i;
      wdata_d = ex_data_i;
      src_d   = 1'b0;
    end else if (lsu_grant) begin
      we_d    = (lsu_addr_i != 5'd0);
      waddr_d = lsu_addr_i;
      wdata_d = lsu_data_i;
      src_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 3'd0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      src_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      src_q    <= src_d;
    end
  end

  assign rf_we_o      = we_q;
  assign rf_waddr_o   = waddr_q;
  assign rf_wdata_o   = wdata_q;
  assign rf_src_o     = src_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_triumph_wb_arbiter.sv
// Self-checking bench for triumph_wb_arbiter: directed scenarios plus random
// traffic compared against a rule-level model of the arbitration policy.
module tb_triumph_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, lsu_valid_i;
  logic [4:0]  ex_addr_i, lsu_addr_i;
  logic [31:0] ex_data_i, lsu_data_i;
  logic        ex_ready_o, lsu_ready_o;
  logic        rf_we_o, rf_src_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [2:0]  starve_cnt_o;

  int checks = 0;
  int errors = 0;

  // Model state: EX loss count and the expected write-port register contents.
  int          m_cnt;
  logic        m_we, m_src;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        last_gex, last_glx;

  triumph_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i), .ex_ready_o(ex_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_src_o(rf_src_o),
    .starve_cnt_o(starve_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_src = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(rf_we_o), 32'd0);
    chk({tag, "_wa"}, 32'(rf_waddr_o), 32'd0);
    chk({tag, "_wd"}, rf_wdata_o, 32'd0);
    chk({tag, "_src"}, 32'(rf_src_o), 32'd0);
    chk({tag, "_cnt"}, 32'(starve_cnt_o), 32'd0);
    chk({tag, "_exr"}, 32'(ex_ready_o), 32'd0);
    chk({tag, "_lsr"}, 32'(lsu_ready_o), 32'd0);
  endtask

  // One clock cycle: drive requests, check readies, clock, check write port.
  task automatic step(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld);
    logic gex, glx;
    ex_valid_i = ev; ex_addr_i = ea; ex_data_i = ed;
    lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
    #1;
    // Policy: a lone requester wins; in a conflict EX wins only once starved.
    gex = ev && (!lv || m_cnt == LIMIT);
    glx = lv && !gex;
    chk("ex_ready", 32'(ex_ready_o), 32'(gex));
    chk("lsu_ready", 32'(lsu_ready_o), 32'(glx));
    chk("starve_cnt", 32'(starve_cnt_o), 32'(m_cnt));
    @(posedge clk_i);
    if (gex) begin
      m_we = (ea != 5'd0); m_wa = ea; m_wd = ed; m_src = 1'b0;
    end else if (glx) begin
      m_we = (la != 5'd0); m_wa = la; m_wd = ld; m_src = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    m_cnt = (ev && lv && !gex) ? m_cnt + 1 : 0;
    #1;
    chk("rf_we", 32'(rf_we_o), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr_o), 32'(m_wa));
    chk("rf_wdata", rf_wdata_o, m_wd);
    chk("rf_src", 32'(rf_src_o), 32'(m_src));
    last_gex = gex; last_glx = glx;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic        pe_v, pl_v;
    logic [4:0]  pe_a, pl_a;
    logic [31:0] pe_d, pl_d;
    ex_valid_i = 1'b0; ex_addr_i = 5'd0; ex_data_i = 32'd0;
    lsu_valid_i = 1'b0; lsu_addr_i = 5'd0; lsu_data_i = 32'd0;
    rst_i = 1'b1;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Single EX write, then an idle cycle drops the enable.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("ex_single_we", 32'(rf_we_o), 32'd1);
    chk("ex_single_data", rf_wdata_o, 32'hDEADBEEF);
    idle();
    chk("ex_single_drop", 32'(rf_we_o), 32'd0);
    chk("idle_hold_addr", 32'(rf_waddr_o), 32'd5);

    // Continuous conflict: LSU, LSU, LSU, EX, LSU.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'(10 + i), 32'h1000_0000 + 32'(i), 1'b1, 5'(20 + i), 32'h2000_0000 + 32'(i));
      chk("starve_src", 32'(rf_src_o), (i == 3) ? 32'd0 : 32'd1);
    end
    idle();

    // Write to x0: accepted, enable stays low, payload updates.
    step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("x0_we", 32'(rf_we_o), 32'd0);
    chk("x0_data", rf_wdata_o, 32'h1234);

    // Alternating singles: eight back-to-back writes.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b1, 5'(1 + i), 32'hA000 + 32'(i), 1'b0, 5'd0, 32'd0);
      else            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + i), 32'hB000 + 32'(i));
      chk("b2b_we", 32'(rf_we_o), 32'd1);
    end

    // Starvation count clears when EX drops its request.
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h66);
    chk("loss2_cnt", 32'(starve_cnt_o), 32'd2);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    chk("drop_cnt", 32'(starve_cnt_o), 32'd0);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88);
    chk("after_drop_src", 32'(rf_src_o), 32'd1);

    // Asynchronous reset mid-cycle with both requesters active.
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 32'hBB);
    ex_valid_i = 1'b1; lsu_valid_i = 1'b1;
    #1 rst_i = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk_i);
    #1 chk_all_zero("rst_edge");
    #2 rst_i = 1'b0;
    model_reset();
    step(1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd13, 32'hD0D0);
    chk("post_rst_src", 32'(rf_src_o), 32'd1);

    // Random traffic; a requester that is not accepted keeps its request.
    pe_v = 1'b0; pl_v = 1'b0; pe_a = 5'd0; pl_a = 5'd0; pe_d = 32'd0; pl_d = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!pe_v) begin
        pe_v = 1'($urandom_range(0, 1)); pe_a = 5'($urandom_range(0, 31)); pe_d = $urandom;
      end
      if (!pl_v) begin
        pl_v = 1'($urandom_range(0, 1)); pl_a = 5'($urandom_range(0, 31)); pl_d = $urandom;
      end
      step(pe_v, pe_a, pe_d, pl_v, pl_a, pl_d);
      if (last_gex) pe_v = 1'b0;
      if (last_glx) pl_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
